// File: rtl/led_pattern_gen.sv
// Multi-LED pattern generator: a shared prescaler tick steps one of four
// runtime-selectable patterns (binary count, bouncing scan, PWM breathe, blink).
module led_pattern_gen #(
    parameter int unsigned NUM_LEDS   = 2,
    parameter int unsigned PRESCALE_W = 11,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PWM_W      = 4
) (
    input  logic                CLK,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                pause,
    input  logic [1:0]          mode,
    output logic                tick,
    output logic [NUM_LEDS-1:0] LED
);

    localparam logic [1:0] MODE_COUNT   = 2'b00;
    localparam logic [1:0] MODE_SCAN    = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_BLINK   = 2'b11;

    localparam logic [PWM_W-1:0]      DUTY_MAX = '1;
    localparam logic [PRESCALE_W-1:0] PRE_MAX  = '1;

    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PWM_W-1:0]      pwm_q, pwm_d;
    logic [PWM_W-1:0]      duty_q, duty_d;
    logic                  duty_dir_q, duty_dir_d;
    logic [NUM_LEDS-1:0]   scan_pos_q, scan_pos_d;
    logic                  scan_dir_q, scan_dir_d;
    logic [NUM_LEDS-1:0]   led_q, led_d;
    logic [1:0]            mode_q;
    logic                  step;
    logic                  mode_chg;

    // Tick is taken straight from the prescaler register, gated by enable.
    assign tick     = enable & (pre_q == PRE_MAX);
    assign step     = tick & ~pause;
    assign mode_chg = (mode != mode_q);
    assign LED      = led_q;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            pre_q      <= '0;
            cnt_q      <= '0;
            pwm_q      <= '0;
            duty_q     <= '0;
            duty_dir_q <= 1'b0;
            scan_pos_q <= NUM_LEDS'(1);
            scan_dir_q <= 1'b0;
            led_q      <= '0;
            mode_q     <= MODE_COUNT;
        end else begin
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            duty_q     <= duty_d;
            duty_dir_q <= duty_dir_d;
            scan_pos_q <= scan_pos_d;
            scan_dir_q <= scan_dir_d;
            led_q      <= led_d;
            mode_q     <= mode;
        end
    end

    // Prescaler, PWM counter and pattern counter.
    always_comb begin
        pre_d = pre_q;
        pwm_d = pwm_q;
        cnt_d = cnt_q;
        if (enable) begin
            pre_d = pre_q + PRESCALE_W'(1);
            pwm_d = pwm_q + PWM_W'(1);
        end
        if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Bouncing scanner; a mode change restarts it from bit 0 moving up.
    always_comb begin
        scan_pos_d = scan_pos_q;
        scan_dir_d = scan_dir_q;
        if (mode_chg) begin
            scan_pos_d = NUM_LEDS'(1);
            scan_dir_d = 1'b0;
        end else if (step && (mode == MODE_SCAN) && (NUM_LEDS > 1)) begin
            if (!scan_dir_q) begin
                if (scan_pos_q[NUM_LEDS-1]) begin
                    scan_pos_d = scan_pos_q >> 1;
                    scan_dir_d = 1'b1;
                end else begin
                    scan_pos_d = scan_pos_q << 1;
                end
            end else begin
                if (scan_pos_q[0]) begin
                    scan_pos_d = scan_pos_q << 1;
                    scan_dir_d = 1'b0;
                end else begin
                    scan_pos_d = scan_pos_q >> 1;
                end
            end
        end
    end

    // Breathe duty triangle; direction flips on the endpoint itself.
    always_comb begin
        duty_d     = duty_q;
        duty_dir_d = duty_dir_q;
        if (mode_chg) begin
            duty_d     = '0;
            duty_dir_d = 1'b0;
        end else if (step && (mode == MODE_BREATHE)) begin
            if (!duty_dir_q) begin
                if (duty_q == DUTY_MAX) begin
                    duty_d     = duty_q - PWM_W'(1);
                    duty_dir_d = 1'b1;
                end else begin
                    duty_d = duty_q + PWM_W'(1);
                end
            end else begin
                if (duty_q == '0) begin
                    duty_d     = duty_q + PWM_W'(1);
                    duty_dir_d = 1'b0;
                end else begin
                    duty_d = duty_q - PWM_W'(1);
                end
            end
        end
    end

    // LED drive, one cycle behind the pattern state.
    always_comb begin
        led_d = '0;
        if (enable) begin
            case (mode)
                MODE_COUNT:   led_d = cnt_q[CNT_W-1 -: NUM_LEDS];
                MODE_SCAN:    led_d = scan_pos_q;
                MODE_BREATHE: led_d = {NUM_LEDS{(pwm_q < duty_q)}};
                MODE_BLINK:   led_d = {NUM_LEDS{cnt_q[0]}};
                default:      led_d = '0;
            endcase
        end
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the two-LED prescaled blinker.
- Drives NUM_LEDS outputs from a shared prescaler tick, in one of four runtime-selectable patterns: binary count, bouncing scanner, PWM breathe, all-blink.
- Sits between board clock/buttons and LED pins. Button inversion and synchronisation are done upstream, so all control inputs arrive synchronous and active-high.

Parameters:
- NUM_LEDS, 2: number of LED outputs, 1..CNT_W.
- PRESCALE_W, 11: prescaler width; one tick every 2^PRESCALE_W enabled cycles.
- CNT_W, 16: pattern counter width.
- PWM_W, 4: PWM counter and duty width.

Ports:
- CLK  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = run; 0 = freeze prescaler/PWM and force LEDs off.
- pause  in  1  1 = hold pattern state; prescaler and tick keep running.
- mode  in  2  00 COUNT, 01 SCAN, 10 BREATHE, 11 BLINK.
- tick  out  1  one-cycle strobe at prescaler wrap.
- LED  out  NUM_LEDS  registered LED drive, 1 = lit.

Behaviour:
- Reset (reset_n low, async):
  - pre, cnt, pwm_cnt, duty, duty_dir, scan_dir, LED, mode_q are all 0.
  - scan_pos = one-hot bit 0.
  - All registers are cleared asynchronously. Release is sampled on CLK.
  - Reset mid-pattern discards all state.
- Prescaler:
  - pre increments by 1 each CLK while enable=1 and wraps at 2^PRESCALE_W-1 -> 0.
  - tick = enable & (pre == all-ones). It is combinational from the register, so exactly 1 cycle per 2^PRESCALE_W enabled cycles.
- Pattern step:
  - A pattern step occurs on any edge where tick=1 and pause=0.
  - cnt += 1 on each step, with modulo 2^CNT_W wrap.
- SCAN state:
  - scan_pos moves one position per step: up while scan_dir=0, down while scan_dir=1.
  - At bit NUM_LEDS-1 going up, move to NUM_LEDS-2 and set scan_dir=1.
  - At bit 0 going down, move to 1 and set scan_dir=0.
  - Sequence for NUM_LEDS=4: 0,1,2,3,2,1,0,1,...
  - NUM_LEDS=1: scan_pos stays at bit 0.
  - scan_pos and scan_dir update only in SCAN mode.
- BREATHE state:
  - pwm_cnt increments every enabled CLK (wrap).
  - On each step, duty triangles: 0..2^PWM_W-1 then back down to 0. The endpoints are not repeated; the flip occurs at the endpoint itself.
  - duty and duty_dir update only in BREATHE mode.
- Mode change:
  - mode_q registers mode each CLK.
  - When mode != mode_q, on that edge: scan_pos = bit0, scan_dir=0, duty=0, duty_dir=0.
  - cnt is NOT cleared.
  - A step coinciding with a mode change: the clear wins for scan/duty; cnt still increments.
- LED next-value (registered, 1-cycle latency from state):
  - enable=0: all 0.
  - COUNT: LED[i] = cnt[CNT_W-NUM_LEDS+i]. The MSB maps to LED[NUM_LEDS-1].
  - SCAN: LED = scan_pos.
  - BREATHE: every bit = (pwm_cnt < duty). duty=0 gives always off; duty max gives on for (2^PWM_W-1) of 2^PWM_W cycles.
  - BLINK: every bit = cnt[0].
- enable falling: state holds. LED is 0 from the next edge. Resume continues from the held pre/cnt.
- pause and enable=0 together: enable=0 dominates, so there is no tick.

Test Plan (NUM_LEDS=4, PRESCALE_W=2, CNT_W=8, PWM_W=2):
- Reset then enable=1, mode=00, 40 cycles:
  - tick pulses at cycles 4,8,12,...
  - cnt reaches 10.
  - LED = cnt[7:4] = 0000.
  - Force cnt wrap 0xFF -> 0x00 after 1024 cycles; LED goes 1111 -> 0000.
- mode=01, 36 cycles:
  - LED sequence per tick: 0001,0010,0100,1000,0100,0010,0001,0010,0100.
  - Each value is seen 1 cycle after its tick.
- mode=10:
  - duty per tick goes 1,2,3,2,1,0,1.
  - With duty=2, LED=1111 for exactly 2 of every 4 cycles.
  - With duty=0, LED=0000 throughout.
- mode=11:
  - LED toggles 0000/1111 every 4 cycles.
  - pause=1 for 12 cycles: tick still pulses 3 times, while LED and cnt are frozen.
- SCAN at position 2 going up, switch to BREATHE then back to SCAN:
  - scan restarts at 0001.
  - cnt unchanged across the switch apart from normal steps.
- Mid-pattern:
  - Assert reset_n=0 between clock edges: LED=0000 and tick=0 immediately, asynchronously.
  - After release, first tick occurs 4 cycles later.
  - enable=0: LED=0000 next edge, pre frozen.
